// File: rtl/shared_pad_pkg.sv
// Shared types and defaults for the tristate pad arbiter.
package shared_pad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int unsigned DEF_GUARD_CYC = 2;
  localparam int unsigned DEF_MAX_HOLD  = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first request at or after rr_ptr, wrapping.
module rr_picker
  import shared_pad_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_nxt,
  output logic [ID_W-1:0]    idx_nxt,
  output logic               any
);

  always_comb begin : pick
    int unsigned j;
    j         = 0;
    grant_nxt = '0;
    idx_nxt   = '0;
    any       = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = i + 32'(rr_ptr);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j[ID_W-1:0]]) begin
        any                   = 1'b1;
        grant_nxt[j[ID_W-1:0]] = 1'b1;
        idx_nxt               = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_pad_arbiter.sv
// Round-robin owner of one tristate pad with bounded hold and an un-driven
// guard gap after every release, so two sources never drive the pad together.
module shared_pad_arbiter
  import shared_pad_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned GUARD_CYC = DEF_GUARD_CYC,
  parameter int unsigned MAX_HOLD  = DEF_MAX_HOLD,
  localparam int unsigned ID_W     = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    owner_id,
  output logic               busy,
  output logic               pad_i,
  output logic               pad_t,
  output logic               timeout
);

  localparam int unsigned HOLD_W  = $clog2(MAX_HOLD) + 1;
  localparam int unsigned GUARD_W = $clog2(GUARD_CYC) + 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);
  localparam logic [ID_W-1:0]    ID_LAST    = ID_W'(NUM_REQ - 1);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [GUARD_W-1:0]   guard_cnt, guard_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [ID_W-1:0]      owner_nxt;
  logic                 busy_nxt, pad_t_nxt, timeout_nxt;
  logic                 others;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant_nxt (pick_grant),
    .idx_nxt   (pick_idx),
    .any       (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      guard_cnt <= '0;
      grant     <= '0;
      owner_id  <= '0;
      busy      <= 1'b0;
      pad_t     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      hold_cnt  <= hold_nxt;
      guard_cnt <= guard_nxt;
      grant     <= grant_nxt;
      owner_id  <= owner_nxt;
      busy      <= busy_nxt;
      pad_t     <= pad_t_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    hold_nxt    = hold_cnt;
    guard_nxt   = guard_cnt;
    grant_nxt   = grant;
    owner_nxt   = owner_id;
    busy_nxt    = busy;
    pad_t_nxt   = pad_t;
    timeout_nxt = 1'b0;
    // The owner's own request bit never counts as competition.
    others      = |(req & ~grant);
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt  = OWN;
          grant_nxt  = pick_grant;
          owner_nxt  = pick_idx;
          busy_nxt   = 1'b1;
          pad_t_nxt  = 1'b1;
          rr_ptr_nxt = (pick_idx == ID_LAST) ? '0 : pick_idx + 1'b1;
          hold_nxt   = '0;
        end
      end
      OWN: begin
        if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + 1'b1;
        if (!req[owner_id] ||
            (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && others)) begin
          state_nxt   = GUARD;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
          pad_t_nxt   = 1'b0;
          guard_nxt   = '0;
          hold_nxt    = '0;
          timeout_nxt = req[owner_id];
        end
      end
      GUARD: begin
        if (guard_cnt == GUARD_LAST) state_nxt = IDLE;
        else                         guard_nxt = guard_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pad_i = busy ? data[owner_id] : 1'b0;
  end

endmodule

// File: tb/tb_shared_pad_arbiter.sv
// Scoreboard bench for shared_pad_arbiter: expected owners are queued with the
// stimulus and checked when the pad changes hands.
module tb_shared_pad_arbiter;
  import shared_pad_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned G = 2;
  localparam int unsigned H = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] data = '0;
  logic [N-1:0] grant;
  logic [1:0]   owner_id;
  logic         busy, pad_i, pad_t, timeout;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  logic [N-1:0] exp_q[$];
  logic         busy_q = 1'b0;
  logic         gap_arm = 1'b0;
  int unsigned  gap = 0;

  always #5 clk = ~clk;

  shared_pad_arbiter #(.NUM_REQ(N), .GUARD_CYC(G), .MAX_HOLD(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .grant    (grant),
    .owner_id (owner_id),
    .busy     (busy),
    .pad_i    (pad_i),
    .pad_t    (pad_t),
    .timeout  (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [N-1:0] oh);
    logic [31:0] r;
    r = 0;
    for (int unsigned i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [N-1:0] bit_of(input int unsigned k);
    logic [N-1:0] v;
    v = '0;
    v[k[1:0]] = 1'b1;
    return v;
  endfunction

  // Ownership monitor: pops the scoreboard on each new owner, measures the gap.
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (rst) begin
      busy_q  = 1'b0;
      gap_arm = 1'b0;
      gap     = 0;
    end else begin
      check("onehot0", {31'b0, $onehot0(grant)}, 1);
      check("pad_t_eq_busy", {31'b0, pad_t}, {31'b0, busy});
      if (busy && !busy_q) begin
        if (exp_q.size() == 0) check("unexpected_grant", {28'b0, grant}, 0);
        else begin
          e = exp_q.pop_front();
          check("grant", {28'b0, grant}, {28'b0, e});
          check("owner_id", {30'b0, owner_id}, idx_of(e));
        end
        if (gap_arm) check("gap", gap, G + 1);
        gap_arm = 1'b0;
      end
      if (!busy && busy_q) begin
        gap_arm = 1'b1;
        gap     = 1;
      end else if (!busy) gap = gap + 1;
      busy_q = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    int unsigned n = 0;
    while (!busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, {31'b0, busy}, 1);
  endtask

  task automatic reset_dut();
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned bad, tmo;

    // T1: reset with all requests asserted
    rst = 1'b1;
    req = 4'hF;
    data = 4'hF;
    tick();
    tick();
    check("t1_grant", {28'b0, grant}, 0);
    check("t1_pad_t", {31'b0, pad_t}, 0);
    check("t1_pad_i", {31'b0, pad_i}, 0);
    check("t1_busy", {31'b0, busy}, 0);
    check("t1_timeout", {31'b0, timeout}, 0);
    check("t1_owner", {30'b0, owner_id}, 0);
    rst = 1'b0;
    req = '0;
    data = '0;
    tick();

    // T2: single requester, one-cycle latency, release then guard
    data = 4'b0100;
    req  = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    check("t2_busy", {31'b0, busy}, 1);
    check("t2_grant", {28'b0, grant}, 4'b0100);
    check("t2_owner", {30'b0, owner_id}, 2);
    check("t2_pad_t", {31'b0, pad_t}, 1);
    check("t2_pad_i_hi", {31'b0, pad_i}, 1);
    data = 4'b0000;
    #1;
    check("t2_pad_i_lo", {31'b0, pad_i}, 0);
    data = 4'b0100;
    req  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_guard_pad_t", {31'b0, pad_t}, 0);
      check("t2_guard_pad_i", {31'b0, pad_i}, 0);
    end
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    check("t2_regrant", {31'b0, busy}, 1);
    req = '0;
    repeat (4) tick();

    // T3: round robin with all requests, each owner releases after 3 cycles
    reset_dut();
    req = 4'hF;
    for (int unsigned i = 0; i < 5; i++) exp_q.push_back(bit_of(i % N));
    for (int unsigned i = 0; i < 5; i++) begin
      wait_busy("t3_wait");
      tick();
      tick();
      req[2'(i % N)] = 1'b0;
      tick();
      check("t3_release", {31'b0, pad_t}, 0);
      req = (i == 4) ? 4'h0 : 4'hF;
    end
    repeat (4) tick();

    // T4: timeout after 16 owned cycles when another requester waits
    reset_dut();
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_busy("t4_wait1");
    repeat (4) tick();
    req = 4'b1010;
    exp_q.push_back(4'b1000);
    repeat (11) tick();
    check("t4_still_own", {31'b0, busy}, 1);
    check("t4_no_early_tmo", {31'b0, timeout}, 0);
    tick();
    check("t4_timeout", {31'b0, timeout}, 1);
    check("t4_revoked", {31'b0, busy}, 0);
    check("t4_revoked_grant", {28'b0, grant}, 0);
    tick();
    check("t4_timeout_pulse", {31'b0, timeout}, 0);
    wait_busy("t4_wait2");
    check("t4_new_grant", {28'b0, grant}, 4'b1000);
    req = '0;
    repeat (4) tick();

    // T5: lone owner is never revoked
    reset_dut();
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_busy("t5_wait");
    bad = 0;
    tmo = 0;
    repeat (40) begin
      tick();
      if (timeout) tmo++;
      if (grant !== 4'b0001 || !busy) bad++;
    end
    check("t5_timeouts", tmo, 0);
    check("t5_hold", bad, 0);
    req = '0;
    repeat (4) tick();

    // T6: reset during ownership, round robin restarts at requester 0
    reset_dut();
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_busy("t6_wait");
    tick();
    tick();
    rst = 1'b1;
    req = 4'b0011;
    tick();
    check("t6_pad_t", {31'b0, pad_t}, 0);
    check("t6_grant", {28'b0, grant}, 0);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_owner", {30'b0, owner_id}, 0);
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    tick();
    check("t6_grant0", {28'b0, grant}, 4'b0001);
    req = '0;
    repeat (4) tick();

    check("q_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

endmodule
